// File: rtl/serial_tofed_tx_pkg.sv
// Shared types and constants for the serial 2-of-5 transmitter.
// Codes are 5 bits, bit 1 (MSB) is sent first.
package SerialTOFEDDefs_2of5;

  typedef enum logic {
    FALSE = 1'b0,
    TRUE  = 1'b1
  } bool_t;

  typedef enum logic [2:0] {
    S_B1 = 3'd0,
    S_B2 = 3'd1,
    S_B3 = 3'd2,
    S_B4 = 3'd3,
    S_B5 = 3'd4
  } tx_state_t;

  localparam logic [4:0] IDLE_CODE = 5'b00000;

  localparam logic [4:0] CODE_TABLE [10] = '{
    5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
    5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100
  };

endpackage

// File: rtl/serial_tofed_tx_encode.sv
// Combinational digit-to-2-of-5 lookup; out-of-range digits map to the
// idle code and raise range_err.
module tofed_encode
  import SerialTOFEDDefs_2of5::*;
(
  input  logic [3:0] digit,
  output logic [4:0] code,
  output logic       range_err
);

  always_comb begin
    code      = IDLE_CODE;
    range_err = 1'b0;
    if (digit <= 4'd9) begin
      code = CODE_TABLE[digit];
    end else begin
      range_err = 1'b1;
    end
  end

endmodule

// File: rtl/serial_tofed_tx.sv
// Serial 2-of-5 transmitter: continuous back-to-back 5-bit frames, one bit
// per clock, with a one-entry holding slot feeding the next frame.
module serial_tofed_tx
  import SerialTOFEDDefs_2of5::*;
(
  input  logic       clk,
  input  logic       resetH,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       dout,
  output logic       frame_start,
  output bool_t      err
);

  tx_state_t  state_q, state_d;
  logic [4:0] shift_q, shift_d;
  logic       hold_valid_q, hold_valid_d;
  logic [4:0] hold_code_q, hold_code_d;
  bool_t      err_q, err_d;

  logic [4:0] enc_code;
  logic       enc_range_err;
  logic       transfer;

  // The holding slot stores the already-encoded code, so a single encoder
  // on digit_in serves both the direct-load and the held path.
  tofed_encode u_encode (
    .digit     (digit_in),
    .code      (enc_code),
    .range_err (enc_range_err)
  );

  assign transfer    = digit_valid && !hold_valid_q;
  assign digit_ready = !hold_valid_q;
  assign dout        = shift_q[4];
  assign frame_start = (state_q == S_B1);
  assign err         = err_q;

  always_comb begin
    state_d      = S_B1;
    shift_d      = {shift_q[3:0], 1'b0};
    hold_valid_d = hold_valid_q;
    hold_code_d  = hold_code_q;
    err_d        = (transfer && enc_range_err) ? TRUE : FALSE;

    case (state_q)
      S_B1:    state_d = S_B2;
      S_B2:    state_d = S_B3;
      S_B3:    state_d = S_B4;
      S_B4:    state_d = S_B5;
      S_B5:    state_d = S_B1;
      default: state_d = S_B1;
    endcase

    if (state_q == S_B5) begin
      // Frame boundary: a held code wins; otherwise a same-edge transfer
      // goes straight into the shifter without touching the slot.
      hold_valid_d = 1'b0;
      if (hold_valid_q) begin
        shift_d = hold_code_q;
      end else if (transfer) begin
        shift_d = enc_code;
      end else begin
        shift_d = IDLE_CODE;
      end
    end else if (transfer) begin
      hold_valid_d = 1'b1;
      hold_code_d  = enc_code;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q      <= S_B1;
      shift_q      <= IDLE_CODE;
      hold_valid_q <= 1'b0;
      hold_code_q  <= IDLE_CODE;
      err_q        <= FALSE;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      hold_code_q  <= hold_code_d;
      err_q        <= err_d;
    end
  end

endmodule
